// File: rtl/event_stamp_fifo.sv
// event_stamp_fifo: tags accepted channel-edge events with a free-running
// cycle timestamp and buffers them in a DEPTH-entry FIFO for a slow reader.
// Build option: define EVT_STAMP_LOSSY_EN to make the input side never stall.
// In that build, events that arrive while the FIFO is full are dropped and counted.
// Outputs are driven only from registered state, so there is no in_* -> out_* path.
`default_nettype none

module event_stamp_fifo #(
  parameter  int DATA_WIDTH    = 8,
  parameter  int STAMP_WIDTH   = 32,
  parameter  int DEPTH         = 16,
  localparam int LB_DATA_WIDTH = $clog2(DATA_WIDTH),
  localparam int AW            = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LB_DATA_WIDTH-1:0] in_index,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [LB_DATA_WIDTH-1:0] out_index,
  output logic [STAMP_WIDTH-1:0]   out_stamp,
  output logic                     out_lost,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [AW:0]              level,
  output logic [15:0]              drop_cnt
);

  logic [STAMP_WIDTH-1:0]   r_stamp;
  logic [AW:0]              r_wr_ptr;
  logic [AW:0]              r_rd_ptr;
  logic [LB_DATA_WIDTH-1:0] r_mem_idx   [DEPTH];
  logic [STAMP_WIDTH-1:0]   r_mem_stamp [DEPTH];

  logic w_full, w_empty, w_in_range, w_store, w_pop;

  // Wrap-bit pointers: equal means empty, same slot on opposite laps means full.
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_in_range = ({1'b0, in_index} < (LB_DATA_WIDTH+1)'(DATA_WIDTH));
  // Out-of-range indices still complete the handshake but are never stored.
  assign w_store    = in_valid && in_ready && w_in_range && !w_full;
  assign w_pop      = !w_empty && out_ready;

  assign out_valid  = !w_empty;
  assign level      = r_wr_ptr - r_rd_ptr;
  // Empty FIFO presents zeros rather than stale or uninitialised RAM contents.
  assign out_index  = w_empty ? '0 : r_mem_idx[r_rd_ptr[AW-1:0]];
  assign out_stamp  = w_empty ? '0 : r_mem_stamp[r_rd_ptr[AW-1:0]];

  // Free-running cycle timestamp, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) r_stamp <= '0;
    else     r_stamp <= r_stamp + STAMP_WIDTH'(1);
  end

  // Pointer update; a same-cycle push and pop advance both pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_store) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage RAM: capture the index and the stamp of the accepting cycle.
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_mem_idx[r_wr_ptr[AW-1:0]]   <= in_index;
      r_mem_stamp[r_wr_ptr[AW-1:0]] <= r_stamp;
    end
  end

`ifdef EVT_STAMP_LOSSY_EN
  logic             r_pend;
  logic [15:0]      r_drop_cnt;
  logic [DEPTH-1:0] r_mem_lost;
  logic             w_drop;

  assign in_ready = 1'b1;
  assign w_drop   = in_valid && w_full && w_in_range;
  assign drop_cnt = r_drop_cnt;
  assign out_lost = !w_empty && r_mem_lost[r_rd_ptr[AW-1:0]];

  // Loss tracking: a drop sets the pending flag (and wins over a store);
  // the next stored entry carries and clears it. Drop counter saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend     <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_drop)       r_pend <= 1'b1;
      else if (w_store) r_pend <= 1'b0;
      if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  // Per-entry loss marker written alongside the data.
  always_ff @(posedge clk) begin
    if (w_store) r_mem_lost[r_wr_ptr[AW-1:0]] <= r_pend;
  end
`else
  assign in_ready = !w_full;
  assign out_lost = 1'b0;
  assign drop_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_event_stamp_fifo.sv
// Directed bench for event_stamp_fifo: a vector table covers the first-event
// latency, fill, full stall and in-order drain. Hand sequences cover reset
// mid-operation, timestamp wrap (on a narrow-stamp instance) and the lossy build.
module tb_event_stamp_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  in_index;
  logic        in_valid, in_ready;
  logic [2:0]  out_index;
  logic [31:0] out_stamp;
  logic        out_lost, out_valid, out_ready;
  logic [4:0]  level;
  logic [15:0] drop_cnt;

  // Narrow-stamp instance used for the wrap test.
  logic [2:0]  w_in_index, w_out_index;
  logic        w_in_valid, w_in_ready, w_out_lost, w_out_valid, w_out_ready;
  logic [3:0]  w_out_stamp;
  logic [2:0]  w_level;
  logic [15:0] w_drop_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  event_stamp_fifo #(.DATA_WIDTH(8), .STAMP_WIDTH(32), .DEPTH(16)) u_dut (
    .clk(clk), .rst(rst), .in_index(in_index), .in_valid(in_valid), .in_ready(in_ready),
    .out_index(out_index), .out_stamp(out_stamp), .out_lost(out_lost), .out_valid(out_valid),
    .out_ready(out_ready), .level(level), .drop_cnt(drop_cnt));

  event_stamp_fifo #(.DATA_WIDTH(8), .STAMP_WIDTH(4), .DEPTH(4)) u_dut_w (
    .clk(clk), .rst(rst), .in_index(w_in_index), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .out_index(w_out_index), .out_stamp(w_out_stamp), .out_lost(w_out_lost), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .level(w_level), .drop_cnt(w_drop_cnt));

  typedef struct {
    logic        vld;
    logic [2:0]  idx;
    logic        ordy;
    logic        e_vld;
    logic [2:0]  e_idx;
    logic [31:0] e_stamp;
    logic [4:0]  e_lvl;
    logic        e_rdy;
  } vec_t;

  vec_t tv [46];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic v, input logic [2:0] ix, input logic r,
                         input logic ev, input logic [2:0] eix, input logic [31:0] es,
                         input logic [4:0] el, input logic erdy);
    tv[i].vld = v;  tv[i].idx = ix; tv[i].ordy = r;
    tv[i].e_vld = ev; tv[i].e_idx = eix; tv[i].e_stamp = es; tv[i].e_lvl = el; tv[i].e_rdy = erdy;
  endtask

  initial begin
    // ---- vector table ----
    // Step n (tv[n-1]) runs in the cycle whose timestamp is n-1.
    for (int i = 0; i < 10; i++) set_vec(i, 0, 0, 0, 0, 0, 0, 0, 1);
    set_vec(10, 1, 3, 1, 1, 3, 10, 1, 1);          // push idx3 at stamp 10
    set_vec(11, 0, 0, 1, 0, 0, 0, 0, 1);           // popped after one cycle
    for (int k = 0; k < 16; k++)                   // fill: idx 0..7,0..7 at stamps 12..27
      set_vec(12 + k, 1, 3'(k % 8), 0, 1, 0, 12, 5'(k + 1), (k < 15));
    set_vec(28, 1, 5, 1, 1, 1, 13, 15, 1);         // full: pop happens, push stalls
    set_vec(29, 1, 5, 0, 1, 1, 13, 16, 0);         // push accepted at stamp 29
    for (int k = 0; k < 16; k++) begin             // drain in order
      if (k < 14)       set_vec(30 + k, 0, 0, 1, 1, 3'((k + 2) % 8), 32'(14 + k), 5'(15 - k), 1);
      else if (k == 14) set_vec(30 + k, 0, 0, 1, 1, 5, 29, 1, 1);
      else              set_vec(30 + k, 0, 0, 1, 0, 0, 0, 0, 1);
    end

    rst = 1'b1; in_valid = 0; in_index = 0; out_ready = 0;
    w_in_valid = 0; w_in_index = 0; w_out_ready = 0;
    tick(); tick();
    check("rst_valid", out_valid, 0);
    check("rst_level", level, 0);
    check("rst_index", out_index, 0);
    check("rst_stamp", out_stamp, 0);
    check("rst_lost",  out_lost, 0);
    check("rst_drop",  drop_cnt, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;

    for (int i = 0; i < 46; i++) begin
      in_valid = tv[i].vld; in_index = tv[i].idx; out_ready = tv[i].ordy;
      tick();
      check($sformatf("v%0d_valid", i), out_valid, tv[i].e_vld);
      check($sformatf("v%0d_level", i), level, tv[i].e_lvl);
      check($sformatf("v%0d_in_ready", i), in_ready, tv[i].e_rdy);
      check($sformatf("v%0d_index", i), out_index, tv[i].e_idx);
      check($sformatf("v%0d_stamp", i), out_stamp, tv[i].e_stamp);
    end
    in_valid = 0; out_ready = 0;

    // ---- reset mid-operation ----
    for (int k = 0; k < 5; k++) begin
      in_valid = 1; in_index = 3'(k); tick();
    end
    in_valid = 0;
    check("pre_rst_level", level, 5);
    rst = 1; tick(); rst = 0;
    check("mid_rst_level", level, 0);
    check("mid_rst_valid", out_valid, 0);

    // ---- restart stamp on main DUT, wrap on narrow DUT ----
    for (int s = 1; s <= 20; s++) begin
      in_valid    = (s == 1);
      in_index    = 3'd2;
      out_ready   = (s == 2);
      w_in_valid  = (s >= 15 && s <= 17);
      w_in_index  = 3'(s - 14);
      w_out_ready = (s >= 18);
      tick();
      case (s)
        1: begin
          check("restart_valid", out_valid, 1);
          check("restart_stamp", out_stamp, 0);
          check("restart_index", out_index, 2);
          check("restart_level", level, 1);
        end
        2:  check("restart_pop_level", level, 0);
        17: begin
          check("wrap_level", w_level, 3);
          check("wrap_idx0", w_out_index, 1);
          check("wrap_stamp0", w_out_stamp, 14);
        end
        18: begin
          check("wrap_idx1", w_out_index, 2);
          check("wrap_stamp1", w_out_stamp, 15);
        end
        19: begin
          check("wrap_idx2", w_out_index, 3);
          check("wrap_stamp2", w_out_stamp, 0);
        end
        20: begin
          check("wrap_empty_valid", w_out_valid, 0);
          check("wrap_empty_level", w_level, 0);
        end
        default: ;
      endcase
    end
    in_valid = 0; out_ready = 0; w_in_valid = 0; w_out_ready = 0;

`ifdef EVT_STAMP_LOSSY_EN
    // ---- lossy: fill, drop 3, then the next stored entry carries the loss ----
    rst = 1; tick(); rst = 0;
    for (int k = 0; k < 16; k++) begin
      in_valid = 1; in_index = 3'(k % 8); tick();
    end
    for (int k = 0; k < 3; k++) begin
      in_valid = 1; in_index = 3'd4; tick();
      check($sformatf("lossy_in_ready%0d", k), in_ready, 1);
    end
    check("lossy_level_full", level, 16);
    check("lossy_drop_cnt", drop_cnt, 3);
    in_valid = 0; out_ready = 1; tick();
    check("lossy_level_pop", level, 15);
    in_valid = 1; in_index = 3'd6; tick();
    in_valid = 1; in_index = 3'd7; tick();
    in_valid = 0;
    check("lossy_drop_cnt_hold", drop_cnt, 3);
    for (int k = 0; k < 13; k++) tick();
    check("lossy_head6_index", out_index, 6);
    check("lossy_head6_lost", out_lost, 1);
    tick();
    check("lossy_head7_index", out_index, 7);
    check("lossy_head7_lost", out_lost, 0);
    out_ready = 0;
`else
    check("lossless_drop_cnt", drop_cnt, 0);
    check("lossless_lost", out_lost, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
